gb_wgt_loader: RTL and testbench
================================

// Module: gb_wgt_loader
// PURPOSE
//  DRAM-side fill engine for the weight global buffer. Accepts a valid/ready word stream from the DRAM
//  interface and writes it, tile by tile, into ping-pong weight banks. Publishes which bank is filled so
//  the MAC-side reader can consume it, and recycles each bank when the reader releases it.
// PARAMETERS
//  NUM_BANK   2    weight banks rotated round-robin (>=2)
//  DEPTH      256  words per bank
//  WIDTH      256  bits per word
//  TILE_W     16   width of tile-count config
// PORTS
//  clock        in   1                   single clock
//  reset        in   1                   asynchronous, active-high
//  start        in   1                   pulse: latch cfg_*, begin load job
//  cfg_len      in   $clog2(DEPTH)+1     words per tile (0 => DEPTH, >DEPTH => DEPTH)
//  cfg_tiles    in   TILE_W              tiles in job
//  busy         out  1                   job in progress
//  done         out  1                   1-cycle pulse: all tiles written and released
//  dram_valid   in   1                   DRAM word valid
//  dram_ready   out  1                   loader accepts word
//  dram_data    in   WIDTH               DRAM word
//  wgt_waddr    out  $clog2(DEPTH)       bank write address
//  wgt_wsel     out  $clog2(NUM_BANK)    bank select for write
//  wgt_wen      out  1                   write strobe
//  wgt_wdata    out  WIDTH               write data
//  rd_valid     out  1                   bank rd_sel holds a complete tile
//  rd_sel       out  $clog2(NUM_BANK)    bank the reader must use
//  rd_len       out  $clog2(DEPTH)+1     words valid in rd_sel
//  rd_release   in   1                   pulse: reader finished bank rd_sel
//  err          out  1                   sticky: rd_release while !rd_valid
// BEHAVIOUR
//  Reset: all outputs 0; wr_bank=rd_bank=0; full[]=0; FSM=IDLE; counters 0.
//  FSM IDLE -> FILL on start (start while busy ignored). cfg_tiles==0: done pulses next cycle, stay IDLE.
//  FILL: dram_ready = !full[wr_bank]. Handshake (valid&ready) at edge t -> wgt_wen=1, waddr=word_cnt,
//   wsel=wr_bank, wdata=dram_data registered, visible in cycle t+1; otherwise wgt_wen=0.
//  Last word of tile (word_cnt==len-1) accepted at t: word_cnt->0, wr_bank advances (mod NUM_BANK),
//   tile_cnt++; full[old bank] and len_q[old bank] set at t+2 (after the write lands).
//  If full[wr_bank]: dram_ready=0 (stall) until that bank is released.
//  Last tile accepted: FILL -> DRAIN; dram_ready=0.
//  DRAIN -> IDLE when full[] all clear and last write landed; done pulses 1 cycle; busy drops same cycle.
//  Reader side: rd_valid=full[rd_bank]; rd_len=len_q[rd_bank]. rd_release&rd_valid: full[rd_bank] cleared
//   next edge, rd_bank advances. rd_release&!rd_valid: ignored, err set (cleared only by reset).
//  Simultaneous: release of bank A and fill-complete of bank B same edge -> both take effect; a released
//   bank that equals wr_bank unblocks dram_ready in the following cycle (no comb path release->ready).
//  Wrap: word_cnt wraps at len; banks wrap at NUM_BANK; tile_cnt saturates at cfg_tiles.
//  Reset mid-job: job abandoned, banks marked empty, no done pulse.
// CONFIGURATION
//  GB_WGT_LOADER_PERF_EN defined: adds outputs stall_cycles[31:0] (cycles in FILL with dram_valid&!dram_ready)
//   and fill_cycles[31:0] (cycles in FILL/DRAIN); both clear on start, saturate at 2^32-1.
//  Undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  gb_pkg: ldr_state_e {IDLE,FILL,DRAIN}; bank index / address width localparams; len type.
//  One sub-module: gb_bank_tracker (full[], len_q[], rd_bank, release/err logic); FSM + write path in top.
// TESTING
//  1 cfg_len=4,cfg_tiles=1, dram_valid=1 -> wen at waddr 0..3 wsel 0; rd_valid 2 cycles after last
//    handshake, rd_len=4; rd_release -> done next cycle.
//  2 cfg_len=8,cfg_tiles=3, no release -> banks 0,1 fill, dram_ready=0 on tile 3; release bank 0 ->
//    tile 3 lands in bank 0, rd_sel sequence 0,1,0.
//  3 cfg_len=0 -> 256 writes per tile, waddr 0..255, rd_len=256.
//  4 rd_release with rd_valid=0 -> err=1, full[]/rd_bank unchanged; err holds until reset.
//  5 release bank 1 on same edge bank 0 completes -> both states correct, no lost tile, no double valid.
//  6 reset asserted mid-tile 2 of 4 -> all outputs 0 asynchronously; new start runs clean job, one done.

Source files
------------

// File: rtl/gb_pkg.sv
// gb_pkg: shared weight-loader FSM encoding, default buffer geometry and derived widths.
package gb_pkg;
    localparam int GB_NUM_BANK = 2;
    localparam int GB_DEPTH    = 256;
    localparam int GB_WIDTH    = 256;
    localparam int GB_TILE_W   = 16;
    localparam int GB_ADDR_W   = $clog2(GB_DEPTH);
    localparam int GB_BANK_W   = $clog2(GB_NUM_BANK);
    localparam int GB_LEN_W    = GB_ADDR_W + 1;
    typedef logic [GB_LEN_W-1:0] len_t;
    typedef logic [1:0] ldr_state_e;
    localparam ldr_state_e IDLE  = 2'd0;
    localparam ldr_state_e FILL  = 2'd1;
    localparam ldr_state_e DRAIN = 2'd2;
endpackage

// File: rtl/gb_bank_tracker.sv
// gb_bank_tracker: per-bank full flags and tile lengths, reader bank pointer, release and error handling.
module gb_bank_tracker
    import gb_pkg::*;
#(
    parameter int NUM_BANK = GB_NUM_BANK,
    parameter int BANK_W   = GB_BANK_W,
    parameter int LEN_W    = GB_LEN_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_set,
    input  logic [BANK_W-1:0]   i_set_bank,
    input  logic [LEN_W-1:0]    i_set_len,
    input  logic                i_release,
    output logic [NUM_BANK-1:0] o_full,
    output logic                o_rd_valid,
    output logic [BANK_W-1:0]   o_rd_sel,
    output logic [LEN_W-1:0]    o_rd_len,
    output logic                o_err
);
    logic [NUM_BANK-1:0] r_full;
    logic [LEN_W-1:0]    r_len_q [NUM_BANK];
    logic [BANK_W-1:0]   r_rd_bank;
    logic                r_err;
    logic                w_rd_valid;
    logic                w_rel;
    logic [BANK_W-1:0]   w_rd_next;

    assign w_rd_valid = r_full[r_rd_bank];
    assign w_rel      = i_release & w_rd_valid;
    assign w_rd_next  = (r_rd_bank == BANK_W'(NUM_BANK - 1)) ? '0 : r_rd_bank + 1'b1;

    // A bank being filled is never full, so set and release never target the same bank.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_full    <= '0;
            r_rd_bank <= '0;
            r_err     <= 1'b0;
            for (int b = 0; b < NUM_BANK; b++) r_len_q[b] <= '0;
        end else begin
            if (i_release && !w_rd_valid) r_err <= 1'b1;
            if (w_rel) r_rd_bank <= w_rd_next;
            for (int b = 0; b < NUM_BANK; b++) begin
                if (i_set && i_set_bank == BANK_W'(b)) begin
                    r_full[b]  <= 1'b1;
                    r_len_q[b] <= i_set_len;
                end else if (w_rel && r_rd_bank == BANK_W'(b)) begin
                    r_full[b] <= 1'b0;
                end
            end
        end
    end

    assign o_full     = r_full;
    assign o_rd_valid = w_rd_valid;
    assign o_rd_sel   = r_rd_bank;
    assign o_rd_len   = r_len_q[r_rd_bank];
    assign o_err      = r_err;
endmodule

// File: rtl/gb_wgt_loader.sv
// gb_wgt_loader: DRAM-to-weight-buffer fill engine writing tiles into round-robin ping-pong banks.
// Define GB_WGT_LOADER_PERF_EN to add the stall/fill cycle counter outputs.
module gb_wgt_loader
    import gb_pkg::*;
#(
    parameter int NUM_BANK = GB_NUM_BANK,
    parameter int DEPTH    = GB_DEPTH,
    parameter int WIDTH    = GB_WIDTH,
    parameter int TILE_W   = GB_TILE_W
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [$clog2(DEPTH):0]      i_cfg_len,
    input  logic [TILE_W-1:0]           i_cfg_tiles,
    output logic                        o_busy,
    output logic                        o_done,
    input  logic                        i_dram_valid,
    output logic                        o_dram_ready,
    input  logic [WIDTH-1:0]            i_dram_data,
    output logic [$clog2(DEPTH)-1:0]    o_wgt_waddr,
    output logic [$clog2(NUM_BANK)-1:0] o_wgt_wsel,
    output logic                        o_wgt_wen,
    output logic [WIDTH-1:0]            o_wgt_wdata,
    output logic                        o_rd_valid,
    output logic [$clog2(NUM_BANK)-1:0] o_rd_sel,
    output logic [$clog2(DEPTH):0]      o_rd_len,
    input  logic                        i_rd_release,
    output logic                        o_err
`ifdef GB_WGT_LOADER_PERF_EN
    ,
    output logic [31:0]                 o_stall_cycles,
    output logic [31:0]                 o_fill_cycles
`endif
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BANK_W = $clog2(NUM_BANK);
    localparam int LEN_W  = ADDR_W + 1;

    ldr_state_e          r_state;
    logic [LEN_W-1:0]    r_len;
    logic [TILE_W-1:0]   r_tiles;
    logic [TILE_W-1:0]   r_tile_cnt;
    logic [ADDR_W-1:0]   r_word_cnt;
    logic [BANK_W-1:0]   r_wr_bank;
    logic                r_wen;
    logic [ADDR_W-1:0]   r_waddr;
    logic [BANK_W-1:0]   r_wsel;
    logic [WIDTH-1:0]    r_wdata;
    logic                r_cpl;
    logic [BANK_W-1:0]   r_cpl_bank;
    logic [LEN_W-1:0]    r_cpl_len;
    logic                r_done;
    logic [NUM_BANK-1:0] w_full;
    logic [LEN_W-1:0]    w_cfg_len;
    logic [BANK_W-1:0]   w_wr_next;
    logic                w_ready;
    logic                w_hs;
    logic                w_last_word;
    logic                w_last_tile;
    logic                w_drained;

    assign w_cfg_len   = (i_cfg_len == '0 || i_cfg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : i_cfg_len;
    assign w_wr_next   = (r_wr_bank == BANK_W'(NUM_BANK - 1)) ? '0 : r_wr_bank + 1'b1;
    assign w_ready     = (r_state == FILL) && !w_full[r_wr_bank];
    assign w_hs        = w_ready & i_dram_valid;
    assign w_last_word = {1'b0, r_word_cnt} == r_len - 1'b1;
    assign w_last_tile = r_tile_cnt + 1'b1 == r_tiles;
    // r_cpl covers the cycle between the last write landing and its bank being marked full.
    assign w_drained   = !(|w_full) && !r_cpl && !r_wen;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_tiles    <= '0;
            r_tile_cnt <= '0;
            r_word_cnt <= '0;
            r_wr_bank  <= '0;
            r_wen      <= 1'b0;
            r_waddr    <= '0;
            r_wsel     <= '0;
            r_wdata    <= '0;
            r_cpl      <= 1'b0;
            r_cpl_bank <= '0;
            r_cpl_len  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_wen  <= w_hs;
            r_cpl  <= w_hs & w_last_word;
            r_done <= 1'b0;
            if (w_hs) begin
                r_waddr    <= r_word_cnt;
                r_wsel     <= r_wr_bank;
                r_wdata    <= i_dram_data;
                r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
            end
            if (w_hs && w_last_word) begin
                r_cpl_bank <= r_wr_bank;
                r_cpl_len  <= r_len;
                r_wr_bank  <= w_wr_next;
                r_tile_cnt <= w_last_tile ? r_tiles : r_tile_cnt + 1'b1;
            end
            if (r_state == IDLE) begin
                if (i_start && i_cfg_tiles == '0) begin
                    r_done <= 1'b1;
                end else if (i_start) begin
                    r_state    <= FILL;
                    r_len      <= w_cfg_len;
                    r_tiles    <= i_cfg_tiles;
                    r_tile_cnt <= '0;
                    r_word_cnt <= '0;
                end
            end else if (r_state == FILL) begin
                if (w_hs && w_last_word && w_last_tile) r_state <= DRAIN;
            end else if (w_drained) begin
                r_state <= IDLE;
                r_done  <= 1'b1;
            end
        end
    end

    gb_bank_tracker #(
        .NUM_BANK (NUM_BANK),
        .BANK_W   (BANK_W),
        .LEN_W    (LEN_W)
    ) u_tracker (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_set      (r_cpl),
        .i_set_bank (r_cpl_bank),
        .i_set_len  (r_cpl_len),
        .i_release  (i_rd_release),
        .o_full     (w_full),
        .o_rd_valid (o_rd_valid),
        .o_rd_sel   (o_rd_sel),
        .o_rd_len   (o_rd_len),
        .o_err      (o_err)
    );

`ifdef GB_WGT_LOADER_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_fill_cycles;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
            r_fill_cycles  <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_stall_cycles <= '0;
            r_fill_cycles  <= '0;
        end else begin
            if (r_state != IDLE && r_fill_cycles != '1) r_fill_cycles <= r_fill_cycles + 1'b1;
            if (r_state == FILL && i_dram_valid && !w_ready && r_stall_cycles != '1)
                r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_fill_cycles  = r_fill_cycles;
`endif

    assign o_busy       = r_state != IDLE;
    assign o_done       = r_done;
    assign o_dram_ready = w_ready;
    assign o_wgt_waddr  = r_waddr;
    assign o_wgt_wsel   = r_wsel;
    assign o_wgt_wen    = r_wen;
    assign o_wgt_wdata  = r_wdata;
endmodule

// File: tb/tb_gb_wgt_loader.sv
// tb_gb_wgt_loader: directed tests of tile fill, bank stall/release, full-depth tiles, err and mid-job reset.
module tb_gb_wgt_loader;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [8:0]   cfg_len = '0;
    logic [15:0]  cfg_tiles = '0;
    logic         busy, done;
    logic         dram_valid = 1'b0;
    logic         dram_ready;
    logic [255:0] dram_data = '0;
    logic [7:0]   waddr;
    logic         wsel, wen;
    logic [255:0] wdata;
    logic         rd_valid, rd_sel;
    logic [8:0]   rd_len;
    logic         rd_release = 1'b0;
    logic         err;

    always #5 clk = ~clk;

    gb_wgt_loader dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_cfg_len(cfg_len), .i_cfg_tiles(cfg_tiles),
        .o_busy(busy), .o_done(done), .i_dram_valid(dram_valid), .o_dram_ready(dram_ready),
        .i_dram_data(dram_data), .o_wgt_waddr(waddr), .o_wgt_wsel(wsel), .o_wgt_wen(wen),
        .o_wgt_wdata(wdata), .o_rd_valid(rd_valid), .o_rd_sel(rd_sel), .o_rd_len(rd_len),
        .i_rd_release(rd_release), .o_err(err)
    );

    typedef struct packed {logic sel; logic [7:0] addr; logic [255:0] data;} wr_t;
    wr_t wq[$];
    int n_cmp = 0, n_bad = 0;
    int seq = 0, hs_n = 0, done_n = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: record handshake, captured write and done pulse, sampled 1ns after the edge.
    task automatic cyc();
        logic hs;
        hs = dram_valid && dram_ready;
        @(posedge clk);
        #1;
        if (hs) begin
            hs_n++;
            seq++;
            dram_data = {8{seq}};
        end
        if (wen) wq.push_back('{wsel, waddr, wdata});
        if (done) done_n++;
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic go(input int len, input int tiles);
        cfg_len = 9'(len);
        cfg_tiles = 16'(tiles);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic rel();
        rd_release = 1'b1;
        cyc();
        rd_release = 1'b0;
    endtask

    task automatic run_hs(input string tag, input int target, input int budget);
        while (hs_n < target && budget > 0) begin
            cyc();
            budget--;
        end
        check(tag, hs_n, target);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = done_n;
        while (done_n == d0 && budget > 0) begin
            cyc();
            budget--;
        end
        check(tag, done_n - d0, 1);
    endtask

    task automatic check_writes(input string tag, input int seq0, input int len, input int sel0, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n && i < wq.size(); i++) begin
            int s;
            logic [255:0] d;
            s = seq0 + i;
            d = {8{s}};
            if (wq[i].sel !== 1'((sel0 + i / len) % 2) || wq[i].addr !== 8'(i % len) || wq[i].data !== d)
                bad++;
        end
        check({tag, "_cnt"}, wq.size(), n);
        check({tag, "_bad"}, bad, 0);
    endtask

    task automatic new_test();
        wq.delete();
        hs_n = 0;
    endtask

    initial begin
        int s0, d0;
        // reset state
        cycles(2);
        check("rst_busy", busy, 0);
        check("rst_ready", dram_ready, 0);
        check("rst_wen", wen, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_len", rd_len, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        cycles(1);

        // 1: single 4-word tile
        new_test();
        s0 = seq;
        dram_valid = 1'b1;
        go(4, 1);
        check("t1_busy", busy, 1);
        run_hs("t1_hs", 4, 20);
        check("t1_rdv_early", rd_valid, 0);
        check("t1_last_addr", waddr, 3);
        cyc();
        check("t1_rd_valid", rd_valid, 1);
        check("t1_rd_len", rd_len, 4);
        check("t1_rd_sel", rd_sel, 0);
        check("t1_ready_drain", dram_ready, 0);
        check_writes("t1_wr", s0, 4, 0, 4);
        rel();
        wait_done("t1_done", 5);
        check("t1_busy_end", busy, 0);
        cyc();
        check("t1_done_pulse", done, 0);

        // zero tiles: immediate done, stay idle
        go(5, 0);
        check("t0_done", done, 1);
        check("t0_busy", busy, 0);
        cyc();
        check("t0_done_pulse", done, 0);

        // 2: three 8-word tiles with a stall on the third
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        new_test();
        s0 = seq;
        go(8, 3);
        run_hs("t2_hs16", 16, 40);
        cycles(5);
        check("t2_stalled_hs", hs_n, 16);
        check("t2_ready_stall", dram_ready, 0);
        check("t2_rd_sel0", rd_sel, 0);
        check("t2_rd_len", rd_len, 8);
        rel();
        check("t2_rd_sel1", rd_sel, 1);
        check("t2_rd_valid1", rd_valid, 1);
        check("t2_ready_unblk", dram_ready, 1);
        run_hs("t2_hs24", 24, 40);
        cyc();
        check_writes("t2_wr", s0, 8, 0, 24);
        rel();
        check("t2_rd_sel2", rd_sel, 0);
        check("t2_rd_valid2", rd_valid, 1);
        rel();
        wait_done("t2_done", 5);

        // 3: cfg_len=0 means full 256-word tile, lands in bank 1
        new_test();
        s0 = seq;
        go(0, 1);
        run_hs("t3_hs", 256, 300);
        cyc();
        check("t3_rd_len", rd_len, 256);
        check("t3_rd_sel", rd_sel, 1);
        check("t3_rd_valid", rd_valid, 1);
        check_writes("t3_wr", s0, 256, 1, 256);
        rel();
        wait_done("t3_done", 5);

        // 4: release with nothing valid
        check("t4_err_pre", err, 0);
        rel();
        check("t4_err", err, 1);
        check("t4_rd_valid", rd_valid, 0);
        check("t4_rd_sel", rd_sel, 0);
        cycles(3);
        check("t4_err_hold", err, 1);

        // 5: release of bank 1 coinciding with bank 0 becoming full
        new_test();
        s0 = seq;
        go(2, 3);
        run_hs("t5_hs4", 4, 20);
        cycles(2);
        check("t5_stall", dram_ready, 0);
        rel();
        run_hs("t5_hs6", 6, 20);
        rel();
        check("t5_rd_valid", rd_valid, 1);
        check("t5_rd_sel", rd_sel, 0);
        check("t5_rd_len", rd_len, 2);
        cyc();
        check("t5_rd_sel_hold", rd_sel, 0);
        check_writes("t5_wr", s0, 2, 0, 6);
        rel();
        wait_done("t5_done", 5);
        check("t5_no_dbl_valid", rd_valid, 0);
        check("t5_err_sticky", err, 1);

        // 6: asynchronous reset mid-job, then a clean job
        new_test();
        go(4, 4);
        run_hs("t6_hs", 6, 20);
        #2 rst = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_ready", dram_ready, 0);
        check("t6_wen", wen, 0);
        check("t6_waddr", waddr, 0);
        check("t6_wdata", wdata, 0);
        check("t6_rd_valid", rd_valid, 0);
        check("t6_err", err, 0);
        d0 = done_n;
        cycles(2);
        rst = 1'b0;
        cycles(2);
        check("t6_no_done", done_n - d0, 0);
        new_test();
        s0 = seq;
        go(3, 1);
        run_hs("t6b_hs", 3, 10);
        cyc();
        check_writes("t6b_wr", s0, 3, 0, 3);
        check("t6b_rd_len", rd_len, 3);
        d0 = done_n;
        rel();
        cycles(6);
        check("t6b_one_done", done_n - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
